seq_det_param: RTL and testbench

Parametrised serial sequence detector and the successor to the fixed 4-bit "1010" detector.
- Pattern, pattern length and overlap mode are programmable at run time through a load strobe.
- Input bits are qualified by a valid strobe.
- Matches are reported as a single-cycle pulse plus a saturating match counter.
- Sits between a serial bit source (deserialiser or line decoder) and control logic that needs frame and sync-word detection.

---
 rtl/seq_det_param_if.sv | 39 +++
 rtl/seq_det_param.sv | 126 ++++++++++++
 tb/tb_seq_det_param.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_param_if.sv
// rtl/seq_det_param_if.sv - bus bundle for the programmable serial sequence detector
//
// Signals (master = bit source / controller side, slave = detector side):
//   data_in, data_valid      serial bit and its qualifier
//   load, pattern, pat_len,  configuration capture strobe and the values it captures
//   overlap_en
//   clr_cnt                  synchronous clear of the match counter
//   match, match_cnt         one-cycle match pulse and saturating match count
//   cfg_err, armed           illegal-load pulse and "legal config held" level

interface seq_det_param_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);

  logic             data_in;
  logic             data_valid;
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap_en;
  logic             clr_cnt;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic             armed;

  modport master (
    output data_in, data_valid, load, pattern, pat_len, overlap_en, clr_cnt,
    input  match, match_cnt, cfg_err, armed
  );

  modport slave (
    input  data_in, data_valid, load, pattern, pat_len, overlap_en, clr_cnt,
    output match, match_cnt, cfg_err, armed
  );

endinterface

// File: rtl/seq_det_param.sv
// rtl/seq_det_param.sv - programmable serial sequence detector with match counter
//
// Ports:
//   clk   clock, all state changes on posedge
//   rst   asynchronous active-low reset
//   bus   seq_det_param_if.slave: serial input, configuration load, counter clear,
//         match pulse, saturating match count, cfg_err pulse, armed level
//
// The pattern is compared MSB-first: bit pat_len-1 of the pattern is the oldest
// received bit, bit 0 the newest. Only the low len_r bits of history and pattern
// take part in the comparison.

module seq_det_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_param_if.slave bus
);

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic             ovl_r;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic             match_r;
  logic             cfg_err_r;
  logic             armed_r;
  logic [CNT_W-1:0] cnt_r;

  logic             load_legal;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W-1:0] len_mask;
  logic             hit;

  always_comb begin
    load_legal = (bus.pat_len != '0) && (bus.pat_len <= LEN_MAX);
    hist_next  = {hist[PAT_W-2:0], bus.data_in};
    // fill saturates so it never wraps back below len_r during long runs
    fill_next  = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
    // shifting by len_r == PAT_W yields zero, so the mask becomes all ones
    len_mask   = ~({PAT_W{1'b1}} << len_r);
    // a load in the same cycle discards the bit, so it can never complete a match
    hit        = (state == RUN) && bus.data_valid && !bus.load &&
                 (fill_next >= len_r) &&
                 (((hist_next ^ pat_r) & len_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= UNCFG;
      pat_r     <= '0;
      len_r     <= '0;
      ovl_r     <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;
      armed_r   <= 1'b0;
      cnt_r     <= '0;
    end else begin
      match_r   <= 1'b0;
      cfg_err_r <= 1'b0;

      // clear wins over a simultaneous increment
      if (bus.clr_cnt) begin
        cnt_r <= '0;
      end else if (hit && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (bus.load) begin
        if (load_legal) begin
          state   <= RUN;
          armed_r <= 1'b1;
          pat_r   <= bus.pattern;
          len_r   <= bus.pat_len;
          ovl_r   <= bus.overlap_en;
          hist    <= '0;
          fill    <= '0;
        end else begin
          // illegal load: keep state and held config untouched
          cfg_err_r <= 1'b1;
        end
      end else begin
        case (state)
          UNCFG: begin
            // unconfigured: incoming bits are ignored
          end
          RUN: begin
            if (bus.data_valid) begin
              hist <= hist_next;
              if (hit) begin
                match_r <= 1'b1;
                // non-overlap restarts the fill so the matched bits cannot be reused;
                // stale history is harmless because fill gates the comparison
                fill    <= ovl_r ? fill_next : '0;
              end else begin
                fill <= fill_next;
              end
            end
          end
          default: state <= UNCFG;
        endcase
      end
    end
  end

  assign bus.match     = match_r;
  assign bus.match_cnt = cnt_r;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.armed     = armed_r;

endmodule

// File: tb/tb_seq_det_param.sv
// tb/tb_seq_det_param.sv - directed scoreboard bench for seq_det_param

module tb_seq_det_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;

  logic clk;
  logic rst;

  seq_det_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_det_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    logic  m;
    logic  e;
    logic  a;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    bus.load       = 1'b0;
    bus.clr_cnt    = 1'b0;
  endtask

  // Expected outputs are queued with the stimulus, then popped once the
  // sampling edge has passed and the registered outputs are visible.
  task automatic tick(input string tag, input logic em, input logic ee, input logic ea);
    exp_t e;
    e.tag = tag;
    e.m   = em;
    e.e   = ee;
    e.a   = ea;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".match"},   8'(bus.match),   8'(e.m));
    check({e.tag, ".cfg_err"}, 8'(bus.cfg_err), 8'(e.e));
    check({e.tag, ".armed"},   8'(bus.armed),   8'(e.a));
    set_idle();
  endtask

  task automatic send(input logic d, input logic em, input string tag);
    bus.data_valid = 1'b1;
    bus.data_in    = d;
    tick(tag, em, 1'b0, 1'b1);
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] len, input logic ovl,
                          input logic ee, input logic ea, input string tag);
    bus.load       = 1'b1;
    bus.pattern    = p;
    bus.pat_len    = len;
    bus.overlap_en = ovl;
    tick(tag, 1'b0, ee, ea);
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
    check({tag, ".cnt"}, 8'(bus.match_cnt), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bits;
    logic [7:0] em;

    rst            = 1'b0;
    bus.pattern    = '0;
    bus.pat_len    = '0;
    bus.overlap_en = 1'b0;
    set_idle();

    // reset held with random valid traffic, then released without a load
    for (int i = 0; i < 4; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in    = 1'($urandom_range(0, 1));
      tick("in_rst", 1'b0, 1'b0, 1'b0);
      chk_cnt("in_rst", 8'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.data_valid = 1'b1;
      bus.data_in    = 1'($urandom_range(0, 1));
      tick("uncfg", 1'b0, 1'b0, 1'b0);
      chk_cnt("uncfg", 8'd0);
    end

    // non-overlap 1010
    load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b1, "ld_nonovl");
    bits = 8'b1010_1010;
    em   = 8'b0001_0001;
    for (int i = 7; i >= 0; i--) send(bits[i], em[i], "nonovl");
    chk_cnt("nonovl", 8'd2);

    // overlap 1010 with gaps; load leaves the counter alone
    load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b1, "ld_ovl");
    chk_cnt("ld_keeps", 8'd2);
    bus.clr_cnt = 1'b1;
    tick("clr", 1'b0, 1'b0, 1'b1);
    chk_cnt("clr", 8'd0);
    em = 8'b0001_0101;
    for (int i = 7; i >= 0; i--) begin
      send(bits[i], em[i], "ovl");
      tick("ovl_gap", 1'b0, 1'b0, 1'b1);
    end
    chk_cnt("ovl", 8'd3);

    // clear on the same cycle as a match
    send(1'b1, 1'b0, "clrhit_a");
    bus.clr_cnt = 1'b1;
    send(1'b0, 1'b1, "clrhit_b");
    chk_cnt("clrhit", 8'd0);

    // length 1, saturation of a 2-bit counter
    load_cfg(8'h01, 4'd1, 1'b0, 1'b0, 1'b1, "ld_len1");
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 1'b1, "len1");
      chk_cnt("len1", (i < 3) ? 8'(i + 1) : 8'd3);
    end
    send(1'b0, 1'b0, "len1_zero");

    // illegal loads leave the config intact
    load_cfg(8'hFF, 4'd0, 1'b1, 1'b1, 1'b1, "ld_len0");
    tick("len0_after", 1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b0, "len0_b0");
    send(1'b1, 1'b1, "len0_b1");
    load_cfg(8'h00, 4'd9, 1'b1, 1'b1, 1'b1, "ld_len9");
    tick("len9_after", 1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b0, "len9_b0");
    send(1'b1, 1'b1, "len9_b1");

    // reload with a simultaneous valid bit discards the bit
    bus.clr_cnt = 1'b1;
    tick("clr2", 1'b0, 1'b0, 1'b1);
    chk_cnt("clr2", 8'd0);
    load_cfg(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b1, "ld_re_a");
    send(1'b1, 1'b0, "re_a1");
    send(1'b0, 1'b0, "re_a2");
    send(1'b1, 1'b0, "re_a3");
    bus.data_valid = 1'b1;
    bus.data_in    = 1'b0;
    load_cfg(8'b0000_0110, 4'd3, 1'b1, 1'b0, 1'b1, "ld_re_b");
    send(1'b1, 1'b0, "re_b1");
    send(1'b1, 1'b0, "re_b2");
    send(1'b0, 1'b1, "re_b3");
    chk_cnt("reload", 8'd1);

    // reset mid-sequence acts immediately and requires a reload
    load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b1, "ld_mid");
    send(1'b1, 1'b0, "mid1");
    send(1'b0, 1'b0, "mid2");
    send(1'b1, 1'b0, "mid3");
    chk_cnt("pre_rst", 8'd1);
    rst = 1'b0;
    #1;
    check("async_rst.armed", 8'(bus.armed), 8'd0);
    chk_cnt("async_rst", 8'd0);
    tick("mid_rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    load_cfg(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b1, "ld_post");
    send(1'b0, 1'b0, "post0");
    bits = 8'b0000_1010;
    em   = 8'b0000_0001;
    for (int i = 3; i >= 0; i--) send(bits[i], em[i], "post");
    chk_cnt("post", 8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
